// File: rtl/muldiv_seq.sv
// Multi-cycle MULTU/DIVU sequencer that borrows the shared EX-stage ALU.
// One shift-add (multiply) or restoring-subtract (divide) step runs per clock.
// HI/LO hold the last completed result for MFHI/MFLO.
module muldiv_seq #(
  parameter int unsigned ITER    = 32,
  parameter logic [3:0]  SIG_AND = 4'b0000,
  parameter logic [3:0]  SIG_ADD = 4'b0010,
  parameter logic [3:0]  SIG_SUB = 4'b0110
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic        flush,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] alu_result,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_signal,
  output logic [4:0]  alu_shamt,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic             op_q;
  logic [CNT_W-1:0] cnt;
  // acc (MULTU) / rem (DIVU)
  logic [W-1:0]     acc_rem;
  // mplr (MULTU) / quot (DIVU)
  logic [W-1:0]     mplr_quot;
  // mcand (MULTU) / dvsr (DIVU)
  logic [W-1:0]     mcand_dvsr;

  logic [W-1:0]     sum;
  logic             carry;
  logic [W-1:0]     sr;
  logic             borrow;
  logic [W-1:0]     nxt_a;
  logic [W-1:0]     nxt_b;

  assign alu_shamt = 5'd0;

  // ALU drive and next working-register values for the current step
  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_signal = SIG_AND;
    sum        = acc_rem;
    carry      = 1'b0;
    sr         = {acc_rem[W-2:0], mplr_quot[W-1]};
    borrow     = 1'b0;
    nxt_a      = acc_rem;
    nxt_b      = mplr_quot;
    if (state == S_RUN) begin
      if (!op_q) begin
        alu_a      = acc_rem;
        alu_b      = mcand_dvsr;
        alu_signal = SIG_ADD;
        if (mplr_quot[0]) begin
          sum   = alu_result;
          carry = (acc_rem[W-1] & mcand_dvsr[W-1]) |
                  ((acc_rem[W-1] | mcand_dvsr[W-1]) & ~alu_result[W-1]);
        end
        nxt_a = {carry, sum[W-1:1]};
        nxt_b = {sum[0], mplr_quot[W-1:1]};
      end else begin
        alu_a      = sr;
        alu_b      = mcand_dvsr;
        alu_signal = SIG_SUB;
        borrow     = (~sr[W-1] & mcand_dvsr[W-1]) |
                     ((~sr[W-1] | mcand_dvsr[W-1]) & alu_result[W-1]);
        // a set msb means the 33-bit shifted remainder always covers dvsr
        if (acc_rem[W-1] | ~borrow) begin
          nxt_a = alu_result;
          nxt_b = {mplr_quot[W-2:0], 1'b1};
        end else begin
          nxt_a = sr;
          nxt_b = {mplr_quot[W-2:0], 1'b0};
        end
      end
    end
  end

  // Sequencer state, working registers and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      op_q       <= 1'b0;
      cnt        <= '0;
      acc_rem    <= '0;
      mplr_quot  <= '0;
      mcand_dvsr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              op_q    <= op;
              cnt     <= '0;
              acc_rem <= '0;
              if (op) begin
                mplr_quot  <= src_a;
                mcand_dvsr <= src_b;
                if (src_b == '0) begin
                  state <= S_DONE;
                  done  <= 1'b1;
                  hi    <= src_a;
                  lo    <= '1;
                end else begin
                  state <= S_RUN;
                  busy  <= 1'b1;
                end
              end else begin
                mplr_quot  <= src_b;
                mcand_dvsr <= src_a;
                state      <= S_RUN;
                busy       <= 1'b1;
              end
            end else begin
              state <= S_IDLE;
            end
          end
          S_RUN: begin
            acc_rem   <= nxt_a;
            mplr_quot <= nxt_b;
            cnt       <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(ITER - 1)) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              hi    <= nxt_a;
              lo    <= nxt_b;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
